key_select: RTL and testbench

- Upstream neighbour of the tone/playback stage; produces the one-hot `key_num[16:0]` that stage consumes.
- Takes the raw per-key hit vector from the projected-keyboard detector, which is noisy and multi-hot. Debounces each key against a slow sample tick.
- Arbitrates to a single sounding key with a minimum note duration.
- Emits a registered one-hot `key_num` plus a one-cycle `note_change` strobe.

---
 rtl/key_select.sv | 170 +++++++++++++++++
 tb/tb_key_select.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_select.sv
// ============================================================================
// Module   : key_select
// Purpose  : Debounces a noisy, multi-hot per-key hit vector against a slow
//            sample tick, then arbitrates to a single sounding key with a
//            minimum note duration. Drives a registered one-hot key_num and
//            a one-cycle note_change strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_select #(
    parameter int NKEYS       = 17,
    parameter int PRESS_CNT   = 3,
    parameter int RELEASE_CNT = 4,
    parameter int MIN_HOLD    = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic [NKEYS-1:0] raw_keys,
    output logic [NKEYS-1:0] key_num,
    output logic             note_on,
    output logic             note_change,
    output logic [NKEYS-1:0] pressed
);

    // Counter values at which the next agreeing sample completes a transition.
    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CNT - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_INIT    = CNT_W'(MIN_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        PEND = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Per-key debounce: count consecutive ticks that disagree with the
    // current debounced state; flip the state once enough have been seen.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        logic [CNT_W-1:0] cnt;
        logic             state_q;
        logic             disagree;
        logic [CNT_W-1:0] last;

        assign disagree   = state_q ? ~raw_keys[i] : raw_keys[i];
        assign last       = state_q ? RELEASE_LAST : PRESS_LAST;
        assign pressed[i] = state_q;

        // Debounce counter and debounced key state, advanced on ticks only.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt     <= '0;
                state_q <= 1'b0;
            end else if (sample_tick) begin
                if (disagree) begin
                    if (cnt >= last) begin
                        state_q <= ~state_q;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NKEYS-1:0] lowest;
    logic             sel_any;
    logic             cur_held;
    logic [CNT_W-1:0] hold_dec;

    // Isolate the lowest set bit: key 0 has priority.
    assign lowest   = pressed & (~pressed + NKEYS'(1));
    assign sel_any  = |pressed;
    assign cur_held = |(pressed & key_num);

    state_t           state, state_n;
    logic [NKEYS-1:0] key_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             change_n;
    logic             release_now;

    assign hold_dec = (sample_tick && hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;

    // Next-state logic: note start, sticky hold, pending release, and the
    // release rule that either hands over to the next key or goes silent.
    always_comb begin
        state_n     = state;
        key_n       = key_num;
        hold_n      = hold_cnt;
        change_n    = 1'b0;
        release_now = 1'b0;

        case (state)
            IDLE: begin
                // A note ending to silence pulses note_change; wait one cycle
                // so two strobes can never be adjacent.
                if (sel_any && !note_change) begin
                    key_n    = lowest;
                    hold_n   = HOLD_INIT;
                    state_n  = PLAY;
                    change_n = 1'b1;
                end
            end
            PLAY: begin
                hold_n = hold_dec;
                if (!cur_held) begin
                    if (hold_cnt != '0) begin
                        state_n = PEND;
                    end else begin
                        release_now = 1'b1;
                    end
                end
            end
            PEND: begin
                hold_n = hold_dec;
                if (cur_held) begin
                    state_n = PLAY;
                end else if (hold_cnt == '0) begin
                    release_now = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                key_n   = '0;
            end
        endcase

        if (release_now) begin
            change_n = 1'b1;
            if (sel_any) begin
                key_n   = lowest;
                hold_n  = HOLD_INIT;
                state_n = PLAY;
            end else begin
                key_n   = '0;
                state_n = IDLE;
            end
        end
    end

    // Registered FSM state and outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            key_num     <= '0;
            hold_cnt    <= '0;
            note_change <= 1'b0;
            note_on     <= 1'b0;
        end else begin
            state       <= state_n;
            key_num     <= key_n;
            hold_cnt    <= hold_n;
            note_change <= change_n;
            note_on     <= |key_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_select.sv
// ============================================================================
// Module   : tb_key_select
// Purpose  : Directed self-checking bench for key_select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_select;

    localparam int NKEYS = 17;

    logic             clock;
    logic             reset;
    logic             sample_tick;
    logic [NKEYS-1:0] raw_keys;
    logic [NKEYS-1:0] key_num;
    logic             note_on;
    logic             note_change;
    logic [NKEYS-1:0] pressed;

    int checks;
    int errors;
    int nc_count;
    int inv_bad;
    int nc0;
    logic [NKEYS-1:0] prev_key;
    logic             prev_nc;

    key_select #(
        .NKEYS(NKEYS), .PRESS_CNT(3), .RELEASE_CNT(4), .MIN_HOLD(8), .CNT_W(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sample_tick(sample_tick),
        .raw_keys   (raw_keys),
        .key_num    (key_num),
        .note_on    (note_on),
        .note_change(note_change),
        .pressed    (pressed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One non-tick clock edge followed by one tick edge; returns just after
    // the tick edge.
    task automatic do_tick();
        @(negedge clock);
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        raw_keys = '0;
        @(negedge clock);
        reset    = 1'b0;
    endtask

    // Invariant monitor and note_change counter, sampled 2 time units after
    // each rising edge.
    always @(posedge clock) begin
        #2;
        if (reset) begin
            prev_key = '0;
            prev_nc  = 1'b0;
        end else begin
            if ($countones(key_num) > 1) inv_bad++;
            if (note_on !== (|key_num)) inv_bad++;
            if (note_change && (key_num == prev_key)) inv_bad++;
            if (note_change && prev_nc) inv_bad++;
            if (!note_change && (key_num != prev_key)) inv_bad++;
            if (note_change) nc_count++;
            prev_key = key_num;
            prev_nc  = note_change;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        nc_count    = 0;
        inv_bad     = 0;
        prev_key    = '0;
        prev_nc     = 1'b0;
        reset       = 1'b1;
        sample_tick = 1'b0;
        raw_keys    = '0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_key_num", 32'(key_num), 32'h0);
        check("rst_note_on", 32'(note_on), 32'h0);
        check("rst_note_change", 32'(note_change), 32'h0);
        check("rst_pressed", 32'(pressed), 32'h0);
        reset = 1'b0;

        // Bounce filter: 1,1,0,1,1,0 on key 5 never reaches three in a row
        nc0 = nc_count;
        raw_keys = 17'h00020; do_tick();
        raw_keys = 17'h00020; do_tick();
        raw_keys = 17'h00000; do_tick();
        raw_keys = 17'h00020; do_tick();
        raw_keys = 17'h00020; do_tick();
        raw_keys = 17'h00000; do_tick();
        repeat (2) @(negedge clock);
        check("bounce_pressed", 32'(pressed), 32'h0);
        check("bounce_key_num", 32'(key_num), 32'h0);
        check("bounce_nc", 32'(nc_count - nc0), 32'h0);

        // Clean press of key 5
        do_reset();
        nc0 = nc_count;
        raw_keys = 17'h00020;
        do_tick(); do_tick();
        check("press_2ticks", 32'(pressed), 32'h0);
        do_tick();
        check("press_3ticks", 32'(pressed), 32'h00020);
        check("press_lag", 32'(key_num), 32'h0);
        @(negedge clock);
        check("press_key_num", 32'(key_num), 32'h00020);
        check("press_nc_pulse", 32'(note_change), 32'h1);
        check("press_note_on", 32'(note_on), 32'h1);
        @(negedge clock);
        check("press_nc_drop", 32'(note_change), 32'h0);
        check("press_nc_count", 32'(nc_count - nc0), 32'h1);

        // Minimum hold: key 2 released after 4 ticks, note lasts 8 ticks
        do_reset();
        raw_keys = 17'h00004;
        do_tick(); do_tick(); do_tick();
        raw_keys = 17'h00000;
        nc0 = nc_count;
        repeat (4) do_tick();
        check("hold_released", 32'(pressed), 32'h0);
        check("hold_mid", 32'(key_num), 32'h00004);
        repeat (4) do_tick();
        check("hold_8ticks", 32'(key_num), 32'h00004);
        @(negedge clock);
        check("hold_end_key", 32'(key_num), 32'h0);
        check("hold_end_nc", 32'(note_change), 32'h1);
        check("hold_end_on", 32'(note_on), 32'h0);
        @(negedge clock);
        check("hold_nc_count", 32'(nc_count - nc0), 32'h2);

        // Sticky note and priority on hand-over
        do_reset();
        raw_keys = 17'h00200;
        do_tick(); do_tick(); do_tick();
        raw_keys = 17'h00202;
        do_tick(); do_tick(); do_tick();
        check("sticky_pressed", 32'(pressed), 32'h00202);
        do_tick();
        check("sticky_key", 32'(key_num), 32'h00200);
        repeat (5) do_tick();
        check("sticky_expired", 32'(key_num), 32'h00200);
        raw_keys = 17'h00002;
        nc0 = nc_count;
        repeat (4) do_tick();
        check("handover_before", 32'(key_num), 32'h00200);
        @(negedge clock);
        check("handover_key", 32'(key_num), 32'h00002);
        check("handover_nc", 32'(note_change), 32'h1);
        repeat (2) @(negedge clock);
        check("handover_nc_count", 32'(nc_count - nc0), 32'h1);

        // Multi-hot onset from IDLE
        do_reset();
        raw_keys = 17'h10410;
        do_tick(); do_tick(); do_tick();
        check("multi_pressed", 32'(pressed), 32'h10410);
        @(negedge clock);
        check("multi_key", 32'(key_num), 32'h00010);

        // Asynchronous reset mid-note
        do_reset();
        raw_keys = 17'h00008;
        do_tick(); do_tick(); do_tick();
        @(negedge clock);
        check("areset_playing", 32'(key_num), 32'h00008);
        #2 reset = 1'b1;
        #1;
        check("areset_key", 32'(key_num), 32'h0);
        check("areset_on", 32'(note_on), 32'h0);
        check("areset_pressed", 32'(pressed), 32'h0);
        check("areset_nc", 32'(note_change), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        do_tick(); do_tick();
        @(negedge clock);
        check("areset_repress_early", 32'(key_num), 32'h0);
        do_tick();
        check("areset_repress_pressed", 32'(pressed), 32'h00008);
        @(negedge clock);
        check("areset_repress_key", 32'(key_num), 32'h00008);

        repeat (2) @(negedge clock);
        check("invariants", 32'(inv_bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
